oled_i2c_rx: RTL and testbench

I2C target-side receiver for the OLED link: decodes the write transactions our I2C master emits. Each transaction is START, address byte, control byte (Co, D/C#), one or more payload bytes, STOP. It ACKs matching writes and presents each payload byte with its Data/Command flag as a one-cycle strobe. Used as the display-side model in system benches and as the front end of the on-FPGA display emulator.

---
 rtl/oled_i2c_pkg.sv | 23 ++
 rtl/i2c_line_sync.sv | 69 ++++++
 rtl/oled_i2c_rx.sv | 164 ++++++++++++++++
 tb/tb_oled_i2c_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/oled_i2c_pkg.sv
// Shared types and constants for the OLED I2C target receiver.
package oled_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_CTRL      = 3'd3,
        ST_CTRL_ACK  = 3'd4,
        ST_DATA      = 3'd5,
        ST_DATA_ACK  = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    localparam logic [6:0] OLED_I2C_ADDR7_DEFAULT = 7'h3C;

    localparam int CO_BIT = 7;
    localparam int DC_BIT = 6;

    localparam logic [7:0] CTRL_CMD  = 8'h80;
    localparam logic [7:0] CTRL_DATA = 8'h40;

endpackage

// File: rtl/i2c_line_sync.sv
// One I2C line: synchronizer, optional glitch filter, rise/fall pulses.
// Filter enabled by defining OLED_I2C_RX_GLITCH_FILTER_EN.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
`ifdef OLED_I2C_RX_GLITCH_FILTER_EN
    ,
    parameter int FILT_CYC    = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   prev_q;

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

`ifdef OLED_I2C_RX_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_CYC + 1);

    logic          filt_q;
    logic [CW-1:0] cnt_q;

    // The filtered level follows only after FILT_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILT_CYC - 1)) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/oled_i2c_rx.sv
// I2C target receiver for the OLED link: address, control byte, payload strobes.
// Optional line glitch filter: OLED_I2C_RX_GLITCH_FILTER_EN.
module oled_i2c_rx
    import oled_i2c_pkg::*;
#(
    parameter logic [6:0] ADDR7       = OLED_I2C_ADDR7_DEFAULT,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_CYC    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       dcn,
    output logic       busy,
    output logic       nack_err
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

`ifdef OLED_I2C_RX_GLITCH_FILTER_EN
    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_scl_sync (
`else
    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
`endif
        .clk(clk), .rst_n(rst_n), .line_i(scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

`ifdef OLED_I2C_RX_GLITCH_FILTER_EN
    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_sda_sync (
`else
    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
`endif
        .clk(clk), .rst_n(rst_n), .line_i(sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       co_q, co_d, dc_q, dc_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] byte_q, byte_d;
    logic       dcn_q, dcn_d, bv_q, bv_d, busy_q, busy_d, nack_q, nack_d;
    logic [7:0] sampled;

    assign sampled = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        co_d     = co_q;
        dc_d     = dc_q;
        sda_oe_d = sda_oe_q;
        byte_d   = byte_q;
        dcn_d    = dcn_q;
        bv_d     = 1'b0;
        busy_d   = busy_q;
        nack_d   = 1'b0;
        // Bus conditions override any SCL edge seen in the same cycle.
        if (start_det) begin
            state_d  = ST_ADDR;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_CTRL, ST_DATA: begin
                    if (scl_rise) begin
                        shift_d = sampled;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (sampled == {ADDR7, 1'b0}) begin
                                    state_d = ST_ADDR_ACK;
                                end else begin
                                    nack_d  = 1'b1;
                                    state_d = ST_WAIT_STOP;
                                end
                            end else if (state_q == ST_CTRL) begin
                                co_d    = sampled[CO_BIT];
                                dc_d    = sampled[DC_BIT];
                                state_d = ST_CTRL_ACK;
                            end else begin
                                byte_d  = sampled;
                                dcn_d   = dc_q;
                                bv_d    = 1'b1;
                                state_d = ST_DATA_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
                    // First SCL fall opens the ACK slot, the second closes it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 3'd0;
                            if (state_q == ST_ADDR_ACK)      state_d = ST_CTRL;
                            else if (state_q == ST_CTRL_ACK) state_d = ST_DATA;
                            else if (co_q)                   state_d = ST_CTRL;
                            else                             state_d = ST_DATA;
                        end
                    end
                end
                ST_IDLE, ST_WAIT_STOP: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= 8'h00;
            cnt_q    <= 3'd0;
            co_q     <= 1'b0;
            dc_q     <= 1'b0;
            sda_oe_q <= 1'b0;
            byte_q   <= 8'h00;
            dcn_q    <= 1'b0;
            bv_q     <= 1'b0;
            busy_q   <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            co_q     <= co_d;
            dc_q     <= dc_d;
            sda_oe_q <= sda_oe_d;
            byte_q   <= byte_d;
            dcn_q    <= dcn_d;
            bv_q     <= bv_d;
            busy_q   <= busy_d;
            nack_q   <= nack_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign byte_valid = bv_q;
    assign byte_out   = byte_q;
    assign dcn        = dcn_q;
    assign busy       = busy_q;
    assign nack_err   = nack_q;

endmodule

// File: tb/tb_oled_i2c_rx.sv
// Directed bench for oled_i2c_rx: bit-banged master, strobe scoreboard.
module tb_oled_i2c_rx;
    import oled_i2c_pkg::*;

    localparam int H = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, byte_valid, dcn, busy, nack_err;
    logic [7:0] byte_out;

    oled_i2c_rx dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_m),
        .sda_oe(sda_oe), .byte_valid(byte_valid), .byte_out(byte_out),
        .dcn(dcn), .busy(busy), .nack_err(nack_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int ack_cnt = 0, nack_cnt = 0, bv_long = 0;
    logic bv_prev = 1'b0, oe_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (byte_valid) begin
            obs_q.push_back({dcn, byte_out});
            if (bv_prev) bv_long++;
        end
        bv_prev = byte_valid;
        if (nack_err) nack_cnt++;
        if (sda_oe && !oe_prev) ack_cnt++;
        oe_prev = sda_oe;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        wait_cyc(2);
        sda_m = 1'b1;
        wait_cyc(H - 2);
        scl = 1'b1;
        wait_cyc(H);
        sda_m = 1'b0;
        wait_cyc(H);
        scl = 1'b0;
    endtask

    task automatic i2c_stop(input logic chk_busy);
        wait_cyc(2);
        sda_m = 1'b0;
        wait_cyc(H - 2);
        scl = 1'b1;
        wait_cyc(H);
        sda_m = 1'b1;
        if (chk_busy) begin
            repeat (2) @(posedge clk);
            #1 check_eq("busy_before_stop_detect", busy, 1);
            @(posedge clk);
            #1 check_eq("busy_after_stop_detect", busy, 0);
        end
        wait_cyc(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            wait_cyc(2);
            sda_m = b[i];
            wait_cyc(H - 2);
            scl = 1'b1;
            wait_cyc(H);
            scl = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        send_bits(b, 8);
        wait_cyc(2);
        sda_m = 1'b1;
        wait_cyc(H - 2);
        scl = 1'b1;
        wait_cyc(H / 2);
        check_eq($sformatf("ack_slot_%02h", b), sda_oe, exp_ack);
        wait_cyc(H - H / 2);
        scl = 1'b0;
    endtask

    task automatic begin_case();
        exp_q.delete();
        obs_q.delete();
        ack_cnt  = 0;
        nack_cnt = 0;
    endtask

    task automatic end_case(input string name, input int exp_acks, input int exp_nacks);
        wait_cyc(4);
        check_eq({name, "_strobe_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check_eq({name, "_strobe"}, obs_q.pop_front(), exp_q.pop_front());
        check_eq({name, "_ack_count"}, ack_cnt, exp_acks);
        check_eq({name, "_nack_count"}, nack_cnt, exp_nacks);
    endtask

    initial begin
        wait_cyc(3);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_byte_valid", byte_valid, 0);
        check_eq("rst_byte_out", byte_out, 8'h00);
        check_eq("rst_dcn", dcn, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_nack", nack_err, 0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Single command byte
        begin_case();
        exp_q.push_back({1'b0, 8'hAE});
        i2c_start();
        wait_cyc(4);
        check_eq("busy_after_start", busy, 1);
        send_byte(8'h78, 1);
        send_byte(CTRL_CMD, 1);
        send_byte(8'hAE, 1);
        i2c_stop(1'b1);
        end_case("cmd_ae", 3, 0);

        // Data stream
        begin_case();
        exp_q.push_back({1'b1, 8'h12});
        exp_q.push_back({1'b1, 8'h34});
        i2c_start();
        send_byte(8'h78, 1);
        send_byte(CTRL_DATA, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        i2c_stop(1'b0);
        end_case("data_stream", 4, 0);

        // Co chain: command then data
        begin_case();
        exp_q.push_back({1'b0, 8'hAF});
        exp_q.push_back({1'b1, 8'h55});
        i2c_start();
        send_byte(8'h78, 1);
        send_byte(8'h80, 1);
        send_byte(8'hAF, 1);
        send_byte(8'h40, 1);
        send_byte(8'h55, 1);
        i2c_stop(1'b0);
        end_case("co_chain", 5, 0);

        // Wrong address and read request
        begin_case();
        i2c_start();
        send_byte(8'h7A, 0);
        send_byte(8'h40, 0);
        send_byte(8'h11, 0);
        i2c_stop(1'b0);
        end_case("addr_7a", 0, 1);
        begin_case();
        i2c_start();
        send_byte(8'h79, 0);
        send_byte(8'h40, 0);
        i2c_stop(1'b0);
        end_case("addr_79", 0, 1);

        // Repeated START after a partial data byte
        begin_case();
        exp_q.push_back({1'b0, 8'hA6});
        i2c_start();
        send_byte(8'h78, 1);
        send_byte(8'h80, 1);
        send_bits(8'hF0, 4);
        i2c_start();
        send_byte(8'h78, 1);
        send_byte(8'h80, 1);
        send_byte(8'hA6, 1);
        i2c_stop(1'b0);
        end_case("rep_start", 5, 0);

        // Asynchronous reset while ACKing
        begin_case();
        i2c_start();
        send_bits(8'h78, 8);
        wait_cyc(H - 2);
        check_eq("oe_before_reset", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1 check_eq("oe_async_reset", sda_oe, 0);
        check_eq("busy_async_reset", busy, 0);
        wait_cyc(3);
        scl = 1'b1;
        sda_m = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(H);
        check_eq("idle_after_reset", busy, 0);
        begin_case();
        exp_q.push_back({1'b0, 8'hAE});
        i2c_start();
        send_byte(8'h78, 1);
        send_byte(8'h80, 1);
        send_byte(8'hAE, 1);
        i2c_stop(1'b0);
        end_case("post_reset", 3, 0);

        check_eq("strobe_single_cycle", bv_long, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
